imem_sync_loadable: RTL and testbench

Parametrised, clocked successor to the combinational instruction ROM.
- Instruction words are loaded at run time through a streaming loader port instead of being hard-wired.
- Fetch is registered: 1-cycle latency with a valid/stall handshake, so the block fits a pipelined or multi-cycle datapath.
- Sits between the PC/fetch logic and the decoder.
- Flags misaligned, out-of-range and never-loaded fetches; it never returns garbage.

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_loader.sv | 79 +++++++
 rtl/imem_sync_loadable.sv | 173 +++++++++++++++++
 tb/tb_imem_sync_loadable.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the loadable synchronous instruction memory.
// Contents: loader state encoding, fetch_err bit positions, default NOP word.
package imem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } load_state_e;

  // Bit positions inside fetch_err
  localparam int unsigned ErrMis = 0;
  localparam int unsigned ErrOob = 1;

  // sll $0,$0,0
  localparam logic [31:0] NopWordDefault = 32'h0000_0000;

endpackage

// File: rtl/imem_loader.sv
// Streaming program loader for imem_sync_loadable.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   load_start_i        pulse: begin a load at word 0 (ignored while busy)
//   load_valid_i        a load word is present this cycle
//   load_last_i         with load_valid_i: final word of the program
//   load_busy_o         loader in LOAD or DONE
//   load_done_o         one-cycle pulse when a load completes
//   load_count_o        words written by the last or current load
//   we_o, widx_o        write strobe and word index into the array
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_start_i,
  input  logic                     load_valid_i,
  input  logic                     load_last_i,
  output logic                     load_busy_o,
  output logic                     load_done_o,
  output logic [$clog2(DEPTH):0]   load_count_o,
  output logic                     we_o,
  output logic [$clog2(DEPTH)-1:0] widx_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  load_state_e   state_q;
  logic [AW-1:0] ptr_q;
  logic [CW-1:0] count_q;
  logic          done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load_start_i) begin
            state_q <= StLoad;
            ptr_q   <= '0;
            count_q <= '0;
          end
        end
        StLoad: begin
          if (load_valid_i) begin
            ptr_q   <= ptr_q + AW'(1);
            count_q <= count_q + CW'(1);
            // Last array slot terminates the load even without load_last
            if (load_last_i || (ptr_q == AW'(DEPTH - 1))) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign load_busy_o  = (state_q != StIdle);
  assign load_done_o  = done_q;
  assign load_count_o = count_q;
  assign we_o         = (state_q == StLoad) && load_valid_i;
  assign widx_o       = ptr_q;

endmodule

// File: rtl/imem_sync_loadable.sv
// Run-time loadable instruction memory with a registered, stallable fetch port.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity, parity_err output).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   fetch_req/fetch_addr        fetch request and byte address
//   fetch_stall                 hold current fetch output, ignore fetch_req
//   instr/instr_valid/fetch_err fetch result one cycle after the request;
//                               fetch_err = {oob, misaligned}, 2'b11 = never loaded
//   parity_err                  (IMEM_PARITY_EN only) stored word failed parity
//   load_*                      streaming loader interface, see imem_loader
module imem_sync_loadable
  import imem_pkg::*;
#(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DEPTH    = 64,
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(NopWordDefault)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_req,
  input  logic [ADDR_W-1:0]      fetch_addr,
  input  logic                   fetch_stall,
  output logic [DATA_W-1:0]      instr,
  output logic                   instr_valid,
  output logic [1:0]             fetch_err,
`ifdef IMEM_PARITY_EN
  output logic                   parity_err,
`endif
  input  logic                   load_start,
  input  logic                   load_valid,
  input  logic [DATA_W-1:0]      load_data,
  input  logic                   load_last,
  output logic                   load_busy,
  output logic                   load_done,
  output logic [$clog2(DEPTH):0] load_count
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int unsigned MW = DATA_W + 1;
`else
  localparam int unsigned MW = DATA_W;
`endif

  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic          busy;

  imem_loader #(
    .DEPTH(DEPTH)
  ) u_loader (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_start_i (load_start),
    .load_valid_i (load_valid),
    .load_last_i  (load_last),
    .load_busy_o  (busy),
    .load_done_o  (load_done),
    .load_count_o (load_count),
    .we_o         (mem_we),
    .widx_o       (mem_widx)
  );

  assign load_busy = busy;

  // Storage: array contents survive reset, only the loaded bits are cleared
  logic [MW-1:0]    mem_q [DEPTH];
  logic [MW-1:0]    wr_word;
  logic [DEPTH-1:0] loaded_q;

`ifdef IMEM_PARITY_EN
  assign wr_word = {^load_data, load_data};
`else
  assign wr_word = load_data;
`endif

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loaded_q <= '0;
    end else if (mem_we) begin
      loaded_q[mem_widx] <= 1'b1;
    end
  end

  // Fetch decode
  logic [AW-1:0]     rd_idx;
  logic              mis;
  logic              oob;
  logic [MW-1:0]     rd_word;
  logic [DATA_W-1:0] res_instr;
  logic [1:0]        res_err;
  logic              res_par;

  assign rd_idx  = fetch_addr[AW+1:2];
  assign mis     = |fetch_addr[1:0];
  // Any set bit above the index field means word address >= DEPTH
  assign oob     = |fetch_addr[ADDR_W-1:AW+2];
  assign rd_word = mem_q[rd_idx];

  always_comb begin
    res_instr = NOP_WORD;
    res_err   = 2'b00;
    res_par   = 1'b0;
    if (mis || oob) begin
      res_err[ErrMis] = mis;
      res_err[ErrOob] = oob;
    end else if (!loaded_q[rd_idx]) begin
      res_err = 2'b11;
`ifdef IMEM_PARITY_EN
    end else if (^rd_word) begin
      res_par = 1'b1;
`endif
    end else begin
      res_instr = rd_word[DATA_W-1:0];
    end
  end

  // Fetch output register
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [1:0]        err_q, err_d;
  logic              par_q, par_d;

  always_comb begin
    instr_d = instr_q;
    valid_d = 1'b0;
    err_d   = err_q;
    par_d   = par_q;
    if (busy) begin
      valid_d = 1'b0;
    end else if (fetch_stall) begin
      valid_d = valid_q;
    end else if (fetch_req && !load_start) begin
      // A same-cycle load_start takes priority and drops the fetch
      instr_d = res_instr;
      valid_d = 1'b1;
      err_d   = res_err;
      par_d   = res_par;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      err_q   <= 2'b00;
      par_q   <= 1'b0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      par_q   <= par_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;
`ifdef IMEM_PARITY_EN
  assign parity_err  = par_q;
`else
  logic unused_par;
  assign unused_par  = par_q ^ res_par ^ (^rd_word);
`endif

endmodule

// File: tb/tb_imem_sync_loadable.sv
// Self-checking bench for imem_sync_loadable (DEPTH=64, 32-bit words).
module tb_imem_sync_loadable;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_stall;
  logic [31:0] instr;
  logic        instr_valid;
  logic [1:0]  fetch_err;
`ifdef IMEM_PARITY_EN
  logic        parity_err;
`endif
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_busy;
  logic        load_done;
  logic [6:0]  load_count;

  always #5 clk = ~clk;

  imem_sync_loadable #(
    .DATA_W   (32),
    .ADDR_W   (32),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_stall (fetch_stall),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err),
`ifdef IMEM_PARITY_EN
    .parity_err  (parity_err),
`endif
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .load_count  (load_count)
  );

  int checks   = 0;
  int failures = 0;
  int done_seen;

  // Reference model: what the program memory should contain
  logic [31:0] model_mem [DEPTH];
  bit          model_loaded [DEPTH];
  logic [31:0] model_instr;
  logic [31:0] wbuf [70];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (load_done === 1'b1) done_seen++;
  endtask

  function automatic void expect_fetch(input logic [31:0] a, output logic [31:0] ei,
                                       output logic [1:0] ee);
    int unsigned w;
    bit mis, oob;
    w   = a / 4;
    mis = (a % 4) != 0;
    oob = w >= DEPTH;
    if (mis || oob) begin
      ei = NOP;
      ee = {oob, mis};
    end else if (!model_loaded[w]) begin
      ei = NOP;
      ee = 2'b11;
    end else begin
      ei = model_mem[w];
      ee = 2'b00;
    end
  endfunction

  task automatic fetch(input logic [31:0] a, input string tag);
    logic [31:0] ei;
    logic [1:0]  ee;
    expect_fetch(a, ei, ee);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req = 1'b0;
    chk({tag, ".valid"}, 64'(instr_valid), 64'd1);
    chk({tag, ".instr"}, 64'(instr), 64'(ei));
    chk({tag, ".err"}, 64'(fetch_err), 64'(ee));
    model_instr = ei;
    step();
    chk({tag, ".idle_valid"}, 64'(instr_valid), 64'd0);
    chk({tag, ".hold"}, 64'(instr), 64'(model_instr));
  endtask

  // Stream n words from wbuf; load_last on the final one if use_last
  task automatic load_words(input int n, input bit use_last, input string tag);
    int exp_cnt;
    done_seen  = 0;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk({tag, ".busy"}, 64'(load_busy), 64'd1);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = wbuf[i];
      load_last  = use_last && (i == n - 1);
      if (i < int'(DEPTH)) begin
        model_mem[i]    = wbuf[i];
        model_loaded[i] = 1'b1;
      end
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    for (int i = 0; i < 3; i++) step();
    exp_cnt = (n < int'(DEPTH)) ? n : int'(DEPTH);
    chk({tag, ".count"}, 64'(load_count), 64'(exp_cnt));
    chk({tag, ".done_pulses"}, 64'(done_seen), 64'd1);
    chk({tag, ".idle"}, 64'(load_busy), 64'd0);
  endtask

  task automatic random_fetches(input int n, input string tag);
    logic [31:0] a;
    int unsigned r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0) a = $urandom;
      else if (r == 1) a = $urandom_range(0, 'h13F);
      else a = $urandom_range(0, 'h11F) & 32'hFFFF_FFFC;
      fetch(a, tag);
    end
  endtask

  initial begin
    rst         = 1'b1;
    fetch_req   = 1'b0;
    fetch_addr  = '0;
    fetch_stall = 1'b0;
    load_start  = 1'b0;
    load_valid  = 1'b0;
    load_data   = '0;
    load_last   = 1'b0;
    done_seen   = 0;
    model_instr = NOP;
    for (int i = 0; i < int'(DEPTH); i++) begin
      model_mem[i]    = '0;
      model_loaded[i] = 1'b0;
    end

    // Reset state
    step();
    step();
    chk("rst.instr", 64'(instr), 64'(NOP));
    chk("rst.valid", 64'(instr_valid), 64'd0);
    chk("rst.err", 64'(fetch_err), 64'd0);
    chk("rst.busy", 64'(load_busy), 64'd0);
    chk("rst.done", 64'(load_done), 64'd0);
    chk("rst.count", 64'(load_count), 64'd0);
    rst = 1'b0;
    step();

    // Three-word program
    wbuf[0] = 32'h2008_0010;
    wbuf[1] = 32'h2009_000A;
    wbuf[2] = 32'h0109_8024;
    load_words(3, 1'b1, "load3");
    fetch(32'h0, "f0");
    fetch(32'h4, "f4");
    fetch(32'h8, "f8");
    fetch(32'h6, "mis6");
    fetch(32'h100, "oob100");
    fetch(32'hC, "unloadedC");

    // Stall holds the previous result; the stalled request is re-presented
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    step();
    chk("stall.first", 64'(instr), 64'h2009_000A);
    fetch_stall = 1'b1;
    fetch_addr  = 32'h8;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.instr", 64'(instr), 64'h2009_000A);
      chk("stall.valid", 64'(instr_valid), 64'd1);
      chk("stall.err", 64'(fetch_err), 64'd0);
    end
    fetch_stall = 1'b0;
    step();
    chk("unstall.instr", 64'(instr), 64'h0109_8024);
    chk("unstall.valid", 64'(instr_valid), 64'd1);
    fetch_req   = 1'b0;
    model_instr = 32'h0109_8024;
    step();

    random_fetches(25, "rnd_a");

    // load_start beats a same-cycle fetch; reset aborts the load
    load_start = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    done_seen  = 0;
    step();
    load_start = 1'b0;
    chk("ldfetch.busy", 64'(load_busy), 64'd1);
    chk("ldfetch.valid", 64'(instr_valid), 64'd0);
    load_valid = 1'b1;
    load_data  = $urandom;
    step();
    chk("busyfetch.valid", 64'(instr_valid), 64'd0);
    fetch_req = 1'b0;
    load_data = $urandom;
    step();
    load_valid = 1'b0;
    rst        = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) model_loaded[i] = 1'b0;
    model_instr = NOP;
    chk("abort.busy", 64'(load_busy), 64'd0);
    chk("abort.count", 64'(load_count), 64'd0);
    chk("abort.instr", 64'(instr), 64'(NOP));
    step();
    chk("abort.no_done", 64'(done_seen), 64'd0);
    fetch(32'h0, "abort.f0");

    // Full-depth load without load_last; two surplus words must be dropped
    for (int i = 0; i < 70; i++) wbuf[i] = $urandom;
    load_words(66, 1'b0, "load64");
    fetch(32'hFC, "fFC");
    fetch(32'h0, "f0_full");
    random_fetches(30, "rnd_b");

    // Short random program with load_last over the full image
    for (int i = 0; i < 70; i++) wbuf[i] = $urandom;
    load_words(int'($urandom_range(1, 20)), 1'b1, "load_rnd");
    random_fetches(20, "rnd_c");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
